seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display driven through a single shared `seven_seg` decoder. Holds four 4-bit digit values, accepts writes from two independent requesters through a round-robin arbiter, and sequences the shared decoder and the anode enables with a dead-time gap between digits to suppress ghosting. Sits between the lab datapath (counters, switches) and the `seven_seg` instance that feeds the board pins.

---
 rtl/seven_seg_scan_ctrl_if.sv | 22 ++
 rtl/seven_seg_scan_ctrl.sv | 104 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Write-request bundle for the two requesters of seven_seg_scan_ctrl.
// The master side drives the requests. The slave side (the controller) returns the acks.
interface seven_seg_scan_ctrl_if;
   logic       a_wr;
   logic [1:0] a_addr;
   logic [3:0] a_data;
   logic       a_ack;
   logic       b_wr;
   logic [1:0] b_addr;
   logic [3:0] b_data;
   logic       b_ack;

   modport master (
      output a_wr, a_addr, a_data, b_wr, b_addr, b_data,
      input  a_ack, b_ack
   );

   modport slave (
      input  a_wr, a_addr, a_data, b_wr, b_addr, b_data,
      output a_ack, b_ack
   );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// It holds four nibbles, which two requesters write through a round-robin arbiter.
// It steps one shared decoder across the digits and inserts dark gaps between them to stop ghosting.
module seven_seg_scan_ctrl #(
   parameter int unsigned PRESCALE = 50000,  // cycles a digit is lit per slot
   parameter int unsigned DEAD     = 16      // all-dark cycles between slots
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seven_seg_scan_ctrl_if.slave req,
   input  logic [3:0]           blank_mask,
   output logic [3:0]           dec_nibble,
   output logic [3:0]           dig_en_n,
   output logic [1:0]           scan_idx
);

   localparam int unsigned MAXC = (PRESCALE > DEAD) ? PRESCALE : DEAD;
   localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] DEAD_LD = CW'(DEAD - 1);
   localparam logic [CW-1:0] SHOW_LD = CW'(PRESCALE - 1);

   typedef enum logic {ST_DEAD, ST_SHOW} state_t;
   typedef enum logic {PRIO_A, PRIO_B}   prio_t;

   state_t      state_q;
   logic [CW-1:0] cnt_q;
   logic [1:0]  idx_q;
   prio_t       prio_q;
   prio_t       prio_d;
   logic [3:0]  digit_q [4];

   logic        grant_a;
   logic        grant_b;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [3:0]  wr_data;

   // Round-robin grant. The priority holder wins a tie. Reset masks both acks.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      grant_a = 1'b0;
      grant_b = 1'b0;
      prio_d  = prio_q;
      if (rst_n) begin
         grant_a = req.a_wr && (!req.b_wr || prio_q == PRIO_A);
         grant_b = req.b_wr && (!req.a_wr || prio_q == PRIO_B);
      end
      if (grant_a)      prio_d = PRIO_B;
      else if (grant_b) prio_d = PRIO_A;
   end

   assign req.a_ack = grant_a;
   assign req.b_ack = grant_b;
   assign wr_en     = grant_a | grant_b;
   assign wr_addr   = grant_a ? req.a_addr : req.b_addr;
   assign wr_data   = grant_a ? req.a_data : req.b_data;

   // Digit storage and arbiter priority. A granted write commits on this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prio_q <= PRIO_A;
         // NOTE: this small register file is cleared on reset because a cleared display is the defined start-up state.
         for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every register samples the values from before the edge.
         prio_q <= prio_d;
         if (wr_en) digit_q[wr_addr] <= wr_data;
      end
   end

   // Scan sequencer. A dark gap of DEAD cycles is followed by a lit slot of PRESCALE cycles, and the digit index then advances.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_DEAD;
         cnt_q   <= DEAD_LD;
         idx_q   <= 2'd0;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end else begin
         case (state_q)
            ST_DEAD: begin
               state_q <= ST_SHOW;
               cnt_q   <= SHOW_LD;
            end
            default: begin
               state_q <= ST_DEAD;
               cnt_q   <= DEAD_LD;
               idx_q   <= idx_q + 2'd1;
            end
         endcase
      end
   end

   // Anode enables are decoded live from state, index and mask. A mask change therefore acts in the same cycle.
   always_comb begin
      dig_en_n = 4'b1111;
      if (state_q == ST_SHOW && !blank_mask[idx_q]) dig_en_n[idx_q] = 1'b0;
   end

   // The decoder input follows the index. The index moves when a dark gap starts, so segments settle before an anode turns on.
   assign dec_nibble = digit_q[idx_q];
   assign scan_idx   = idx_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed testbench for seven_seg_scan_ctrl with PRESCALE=4 and DEAD=2 (a 6-cycle slot).
module tb_seven_seg_scan_ctrl;
   localparam int PS   = 4;
   localparam int DT   = 2;
   localparam int SLOT = PS + DT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] blank_mask = 4'h0;
   logic [3:0] dec_nibble;
   logic [3:0] dig_en_n;
   logic [1:0] scan_idx;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   seven_seg_scan_ctrl_if bus ();

   seven_seg_scan_ctrl #(.PRESCALE(PS), .DEAD(DT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (bus.slave),
      .blank_mask (blank_mask),
      .dec_nibble (dec_nibble),
      .dig_en_n   (dig_en_n),
      .scan_idx   (scan_idx)
   );

   always #5 clk = ~clk;

   // Advance one cycle. Sampling and driving happen 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_bus();
      bus.a_wr = 1'b0; bus.a_addr = 2'd0; bus.a_data = 4'h0;
      bus.b_wr = 1'b0; bus.b_addr = 2'd0; bus.b_data = 4'h0;
   endtask

   task automatic do_reset();
      idle_bus();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   // Expected anode pattern for cycle c: dark for the first DT cycles of each slot, then the slot's digit, unless it is masked.
   function automatic logic [3:0] exp_en(int c, logic [3:0] m);
      int idx;
      logic [3:0] one_hot;
      idx = (c / SLOT) % 4;
      one_hot = 4'b0001 << idx;
      if ((c % SLOT) < DT || m[idx]) return 4'b1111;
      return ~one_hot;
   endfunction

   function automatic logic [1:0] exp_idx(int c);
      return 2'((c / SLOT) % 4);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      bus.a_wr = 1'b1; bus.a_addr = 2'd1; bus.a_data = 4'h7;
      bus.b_wr = 1'b1; bus.b_addr = 2'd2; bus.b_data = 4'h3;
      tick();
      checks++; if (bus.a_ack !== 1'b0) begin errors++; $display("FAIL reset_a_ack: got %b expected 0", bus.a_ack); end
      checks++; if (bus.b_ack !== 1'b0) begin errors++; $display("FAIL reset_b_ack: got %b expected 0", bus.b_ack); end
      checks++; if (dig_en_n !== 4'b1111) begin errors++; $display("FAIL reset_dig_en_n: got %b expected 1111", dig_en_n); end
      checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL reset_scan_idx: got %0d expected 0", scan_idx); end
      checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL reset_dec_nibble: got %h expected 0", dec_nibble); end
      tick();
      idle_bus();
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic test_scan();
      for (int i = 0; i < 28; i++) begin
         checks++; if (dig_en_n !== exp_en(cyc, 4'h0)) begin errors++; $display("FAIL scan_dig_en_n cyc %0d: got %b expected %b", cyc, dig_en_n, exp_en(cyc, 4'h0)); end
         checks++; if (scan_idx !== exp_idx(cyc)) begin errors++; $display("FAIL scan_idx cyc %0d: got %0d expected %0d", cyc, scan_idx, exp_idx(cyc)); end
         checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL scan_dec_nibble cyc %0d: got %h expected 0", cyc, dec_nibble); end
         tick();
      end
   endtask

   task automatic test_single_write();
      do_reset();
      bus.a_wr = 1'b1; bus.a_addr = 2'd2; bus.a_data = 4'h9;
      #1;
      checks++; if (bus.a_ack !== 1'b1) begin errors++; $display("FAIL single_a_ack: got %b expected 1", bus.a_ack); end
      checks++; if (bus.b_ack !== 1'b0) begin errors++; $display("FAIL single_b_ack: got %b expected 0", bus.b_ack); end
      tick();
      idle_bus();
      for (int i = 0; i < 24; i++) begin
         logic [3:0] exp_n;
         exp_n = (exp_idx(cyc) == 2'd2) ? 4'h9 : 4'h0;
         checks++; if (dec_nibble !== exp_n) begin errors++; $display("FAIL single_dec_nibble cyc %0d: got %h expected %h", cyc, dec_nibble, exp_n); end
         tick();
      end
   endtask

   task automatic test_contention();
      logic [2:0] exp_a;
      logic [2:0] exp_b;
      do_reset();
      exp_a = 3'b101;  // grant order A, B, A
      exp_b = 3'b010;
      bus.a_wr = 1'b1; bus.a_addr = 2'd1; bus.a_data = 4'h5;
      bus.b_wr = 1'b1; bus.b_addr = 2'd1; bus.b_data = 4'h7;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (bus.a_ack !== exp_a[i]) begin errors++; $display("FAIL contend_a_ack step %0d: got %b expected %b", i, bus.a_ack, exp_a[i]); end
         checks++; if (bus.b_ack !== exp_b[i]) begin errors++; $display("FAIL contend_b_ack step %0d: got %b expected %b", i, bus.b_ack, exp_b[i]); end
         checks++; if (bus.a_ack && bus.b_ack) begin errors++; $display("FAIL contend_two_acks step %0d: got 11 expected at most one", i); end
         tick();
      end
      // A won last, so B now holds priority for the next tie.
      #1;
      checks++; if (bus.b_ack !== 1'b1 || bus.a_ack !== 1'b0) begin errors++; $display("FAIL contend_prio_b: got a=%b b=%b expected a=0 b=1", bus.a_ack, bus.b_ack); end
      bus.a_wr = 1'b0;
      bus.b_wr = 1'b0;
      #1;
      while (exp_idx(cyc) != 2'd1) tick();
      checks++; if (dec_nibble !== 4'h5) begin errors++; $display("FAIL contend_digit1: got %h expected 5", dec_nibble); end
      idle_bus();
   endtask

   task automatic test_blank();
      do_reset();
      blank_mask = 4'b0100;
      for (int i = 0; i < 24; i++) begin
         checks++; if (dig_en_n !== exp_en(cyc, blank_mask)) begin errors++; $display("FAIL blank_dig_en_n cyc %0d: got %b expected %b", cyc, dig_en_n, exp_en(cyc, blank_mask)); end
         checks++; if (scan_idx !== exp_idx(cyc)) begin errors++; $display("FAIL blank_scan_idx cyc %0d: got %0d expected %0d", cyc, scan_idx, exp_idx(cyc)); end
         tick();
      end
      while (cyc < 38) tick();  // lit part of slot 6 (idx 2)
      checks++; if (dig_en_n !== 4'b1111) begin errors++; $display("FAIL blank_masked_lit: got %b expected 1111", dig_en_n); end
      blank_mask = 4'b0000;
      #1;
      checks++; if (dig_en_n !== 4'b1011) begin errors++; $display("FAIL blank_unmask_same_cycle: got %b expected 1011", dig_en_n); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.a_wr = 1'b1; bus.a_addr = 2'd0; bus.a_data = 4'h3;
      tick();
      idle_bus();
      while (cyc < 15) tick();  // lit part of slot 2
      checks++; if (dig_en_n !== 4'b1011) begin errors++; $display("FAIL midrst_pre_dig_en_n: got %b expected 1011", dig_en_n); end
      bus.b_wr = 1'b1; bus.b_addr = 2'd2; bus.b_data = 4'h6;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.b_ack !== 1'b0) begin errors++; $display("FAIL midrst_b_ack: got %b expected 0", bus.b_ack); end
      tick();
      idle_bus();
      rst_n = 1'b1;
      cyc = 0;
      checks++; if (dig_en_n !== 4'b1111) begin errors++; $display("FAIL midrst_dig_en_n: got %b expected 1111", dig_en_n); end
      checks++; if (scan_idx !== 2'd0) begin errors++; $display("FAIL midrst_scan_idx: got %0d expected 0", scan_idx); end
      for (int i = 0; i < 24; i++) begin
         checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL midrst_dec_nibble cyc %0d: got %h expected 0", cyc, dec_nibble); end
         checks++; if (dig_en_n !== exp_en(cyc, 4'h0)) begin errors++; $display("FAIL midrst_scan cyc %0d: got %b expected %b", cyc, dig_en_n, exp_en(cyc, 4'h0)); end
         tick();
      end
   endtask

   task automatic test_lit_write();
      do_reset();
      while (cyc < 3) tick();
      checks++; if (dig_en_n !== 4'b1110) begin errors++; $display("FAIL lit_pre_dig_en_n: got %b expected 1110", dig_en_n); end
      bus.a_wr = 1'b1; bus.a_addr = 2'd0; bus.a_data = 4'hF;
      #1;
      checks++; if (bus.a_ack !== 1'b1) begin errors++; $display("FAIL lit_a_ack: got %b expected 1", bus.a_ack); end
      checks++; if (dec_nibble !== 4'h0) begin errors++; $display("FAIL lit_before_commit: got %h expected 0", dec_nibble); end
      tick();
      idle_bus();
      checks++; if (dec_nibble !== 4'hF) begin errors++; $display("FAIL lit_dec_nibble_c4: got %h expected F", dec_nibble); end
      checks++; if (dig_en_n !== 4'b1110) begin errors++; $display("FAIL lit_dig_en_n_c4: got %b expected 1110", dig_en_n); end
      tick();
      checks++; if (dig_en_n !== 4'b1110) begin errors++; $display("FAIL lit_dig_en_n_c5: got %b expected 1110", dig_en_n); end
      checks++; if (dec_nibble !== 4'hF) begin errors++; $display("FAIL lit_dec_nibble_c5: got %h expected F", dec_nibble); end
      tick();
      checks++; if (dig_en_n !== 4'b1111) begin errors++; $display("FAIL lit_dig_en_n_c6: got %b expected 1111", dig_en_n); end
   endtask

   initial begin
      idle_bus();
      test_reset();
      test_scan();
      test_single_write();
      test_contention();
      test_blank();
      test_reset_mid();
      test_lit_write();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
